// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side bus: register addresses,
// status bit layout and the reset baud divisor.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Status byte layout: {2'b0, count[2:0], overrun, tbr, rda}
    localparam int STAT_RDA = 0;
    localparam int STAT_TBR = 1;
    localparam int STAT_OVR = 2;
    localparam int STAT_CNT = 3;
    localparam int STAT_CNT_W = 3;

    // 100 MHz clock, 9600 baud, 16x oversample
    localparam logic [15:0] DEFAULT_DIV = 16'd650;

endpackage

// File: rtl/spart_bus_if_if.sv
// Control half of the driver I/O bus; the shared 8-bit databus is a plain
// inout net so each side can tri-state it.
interface spart_bus_if_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;

    modport master (output iocs, output iorw, output ioaddr);
    modport slave  (input  iocs, input  iorw, input  ioaddr);

endinterface

// File: rtl/spart_rx_fifo.sv
// Receive FIFO: DEPTH-entry ring buffer with combinational head, occupancy
// count and a one-cycle overflow pulse when a push has to be dropped.
module spart_rx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        overflow = push && !do_push;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/spart_bus_if.sv
// Responder for the SPART driver bus: decodes register accesses, owns the
// transmit holding register, status/overrun, the baud divisor and the RX FIFO.
module spart_bus_if #(
    parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV,
    parameter int          RX_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    spart_bus_if_if.slave     bus,
    inout  wire  [7:0]        databus,
    output logic              rda,
    output logic              tbr,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       divisor,
    output logic              div_load
);

    import spart_pkg::*;

    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic          rd_en;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [7:0]    rd_data;
    logic [7:0]    cnt_ext;

    logic          hold_full_q, hold_full_d;
    logic [7:0]    hold_q, hold_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   div_q, div_d;
    logic          div_load_q, div_load_d;

    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_overflow;
    logic          full_unused;

    spart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

    assign full_unused = fifo_full;

    assign rd_en    = bus.iocs && bus.iorw;
    assign wr_en    = bus.iocs && !bus.iorw;
    assign wr_data  = databus;
    assign fifo_pop = rd_en && (bus.ioaddr == ADDR_BUF);
    assign cnt_ext  = 8'(fifo_count);

    assign rda      = !fifo_empty;
    assign tbr      = !hold_full_q;
    // Shifter may take the byte in the very cycle after it was written
    assign tx_load  = hold_full_q && !tx_busy;
    assign tx_data  = hold_q;
    assign divisor  = div_q;
    assign div_load = div_load_q;

    always_comb begin
        rd_data = 8'h00;
        unique case (bus.ioaddr)
            ADDR_BUF: begin
                rd_data = fifo_empty ? 8'h00 : fifo_head;
            end
            ADDR_STAT: begin
                rd_data[STAT_RDA]                 = rda;
                rd_data[STAT_TBR]                 = tbr;
                rd_data[STAT_OVR]                 = overrun_q;
                rd_data[STAT_CNT +: STAT_CNT_W]   = cnt_ext[STAT_CNT_W-1:0];
            end
            ADDR_DBL: rd_data = div_q[7:0];
            ADDR_DBH: rd_data = div_q[15:8];
        endcase
    end

    assign databus = rd_en ? rd_data : 8'hzz;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        overrun_d   = overrun_q;
        div_d       = div_q;
        div_load_d  = 1'b0;

        if (tx_load) begin
            hold_full_d = 1'b0;
        end else if (wr_en && (bus.ioaddr == ADDR_BUF) && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = wr_data;
        end

        if (wr_en && (bus.ioaddr == ADDR_DBL)) begin
            div_d[7:0] = wr_data;
        end
        // High byte is written last, so it alone triggers the reload
        if (wr_en && (bus.ioaddr == ADDR_DBH)) begin
            div_d[15:8] = wr_data;
            div_load_d  = 1'b1;
        end

        if (fifo_overflow) begin
            overrun_d = 1'b1;
        end else if (rd_en && (bus.ioaddr == ADDR_STAT)) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_q      <= 8'h00;
            overrun_q   <= 1'b0;
            div_q       <= DEFAULT_DIV;
            div_load_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            overrun_q   <= overrun_d;
            div_q       <= div_d;
            div_load_q  <= div_load_d;
        end
    end

endmodule

// File: tb/tb_spart_bus_if.sv
// Directed test-plan sequences followed by randomized bus/RX/TX traffic, all
// checked against a queue-based reference model of the register map.
module tb_spart_bus_if;

    import spart_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rda, tbr, tx_load, div_load;
    logic [7:0]  tx_data;
    logic [15:0] divisor;
    wire  [7:0]  databus;
    logic        tb_drv = 1'b0;
    logic [7:0]  tb_wdata = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    bit verbose = 1'b1;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_ovr;
    bit          m_full;
    logic [7:0]  m_hold;
    logic [15:0] m_div;
    bit          m_dl;

    spart_bus_if_if bus_i ();

    assign databus = tb_drv ? tb_wdata : 8'hzz;

    spart_bus_if #(
        .DEFAULT_DIV (16'd650),
        .RX_DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_i.slave),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .divisor  (divisor),
        .div_load (div_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr  = 1'b0;
        m_full = 1'b0;
        m_hold = 8'h00;
        m_div  = 16'd650;
        m_dl   = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] a);
        logic [7:0] cnt;
        cnt = 8'(m_q.size());
        case (a)
            ADDR_BUF:  return (m_q.size() > 0) ? m_q[0] : 8'h00;
            ADDR_STAT: return {2'b00, cnt[2:0], m_ovr, !m_full, m_q.size() != 0};
            ADDR_DBL:  return m_div[7:0];
            default:   return m_div[15:8];
        endcase
    endfunction

    // One bus cycle: drive at negedge, check just after, advance model at posedge
    task automatic cycle(input bit r, input bit cs, input bit rw, input logic [1:0] a,
                         input logic [7:0] wd, input bit rv, input logic [7:0] rd,
                         input bit busy);
        bit         exp_ld;
        bit         pop;
        bit         full_now;
        logic [7:0] exp_rd;
        @(negedge clk);
        rst          = r;
        bus_i.iocs   = cs;
        bus_i.iorw   = rw;
        bus_i.ioaddr = a;
        tb_wdata     = wd;
        tb_drv       = cs && !rw;
        rx_valid     = rv;
        rx_data      = rd;
        tx_busy      = busy;
        #1;
        exp_ld = m_full && !busy;
        exp_rd = model_read(a);
        chk("rda", 16'(rda), 16'(m_q.size() != 0));
        chk("tbr", 16'(tbr), 16'(!m_full));
        chk("divisor", divisor, m_div);
        chk("div_load", 16'(div_load), 16'(m_dl));
        chk("tx_load", 16'(tx_load), 16'(exp_ld));
        chk("tx_data", 16'(tx_data), 16'(m_hold));
        if (cs && rw) chk("rdata", 16'(databus), 16'(exp_rd));
        if (verbose)
            $display("[TB] txn rst=%0d cs=%0d rw=%0d a=%0d wd=%h rv=%0d rd=%h busy=%0d bus=%h",
                     r, cs, rw, a, wd, rv, rd, busy, databus);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            full_now = (m_q.size() == DEPTH);
            pop = cs && rw && (a == ADDR_BUF) && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (rv) begin
                if (!full_now || pop) m_q.push_back(rd);
                else m_ovr = 1'b1;
            end
            if (!(rv && full_now && !pop) && cs && rw && (a == ADDR_STAT)) m_ovr = 1'b0;
            if (exp_ld) m_full = 1'b0;
            else if (cs && !rw && (a == ADDR_BUF) && !m_full) begin
                m_full = 1'b1;
                m_hold = wd;
            end
            m_dl = cs && !rw && (a == ADDR_DBH);
            if (cs && !rw && (a == ADDR_DBL)) m_div[7:0]  = wd;
            if (cs && !rw && (a == ADDR_DBH)) m_div[15:8] = wd;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit busy);
        cycle(1'b0, 1'b1, 1'b0, a, d, 1'b0, 8'h00, busy);
    endtask

    task automatic rd(input logic [1:0] a, input bit busy);
        cycle(1'b0, 1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00, busy);
    endtask

    task automatic push(input logic [7:0] d, input bit busy);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, d, busy);
    endtask

    task automatic idle(input bit busy);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, busy);
    endtask

    initial begin
        logic [7:0] seq [5];
        bus_i.iocs   = 1'b0;
        bus_i.iorw   = 1'b0;
        bus_i.ioaddr = 2'b00;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state and status
        idle(1'b0);
        rd(ADDR_STAT, 1'b0);

        // Transmit path
        wr(ADDR_BUF, 8'h41, 1'b0);
        idle(1'b0);
        idle(1'b1);
        wr(ADDR_BUF, 8'h77, 1'b1);
        wr(ADDR_BUF, 8'h88, 1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Receive path with overrun
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) push(seq[i], 1'b0);
        rd(ADDR_STAT, 1'b0);
        rd(ADDR_STAT, 1'b0);
        for (int i = 0; i < 5; i++) rd(ADDR_BUF, 1'b0);
        rd(ADDR_STAT, 1'b0);

        // Simultaneous push and pop on a full FIFO
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, ADDR_BUF, 8'h00, 1'b1, 8'h66, 1'b0);
        rd(ADDR_STAT, 1'b0);
        for (int i = 0; i < 5; i++) rd(ADDR_BUF, 1'b0);

        // Divisor programming
        wr(ADDR_DBL, 8'h15, 1'b0);
        wr(ADDR_DBH, 8'h00, 1'b0);
        idle(1'b0);
        idle(1'b0);
        rd(ADDR_DBL, 1'b0);
        rd(ADDR_DBH, 1'b0);
        wr(ADDR_STAT, 8'hFF, 1'b0);
        rd(ADDR_STAT, 1'b0);

        // Reset in the middle of activity
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b1);
        wr(ADDR_BUF, 8'h5A, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
        idle(1'b0);
        rd(ADDR_STAT, 1'b0);

        // Randomized traffic
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  ($urandom_range(0, 2) == 0),
                  8'($urandom),
                  1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
